// File: rtl/trng_bram_arbiter_pkg.sv
// trng_bram_pkg: shared constants and types for the TRNG BRAM arbiter.
//   BYTE_WE_ALL : byte-enable pattern for a full-word write
//   ADDR_SHIFT  : word index -> byte address shift (4-byte words)
//   arb_sel_e   : arbitration side, used for rr_last and the winner
package trng_bram_pkg;

  localparam logic [3:0] BYTE_WE_ALL = 4'hF;
  localparam int         ADDR_SHIFT  = 2;

  typedef enum logic {ARB_WR, ARB_RD} arb_sel_e;

endpackage

// File: rtl/trng_bram_rd_pipe.sv
// trng_bram_rd_pipe: read-valid delay line for the BRAM read latency.
//   clk, rst (async, active-low)
//   flush : drops every pending read pulse on the next edge
//   issue : read granted this cycle (access goes out next cycle)
//   valid : high RD_LAT+1 cycles after issue
module trng_bram_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic issue,
  output logic valid
);

  // Stage 0 marks the cycle the BRAM access is on the port; the last stage
  // lines up with the BRAM data coming back.
  logic [RD_LAT:0] vld_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[RD_LAT-1:0], issue};
  end

  assign valid = vld_pipe[RD_LAT];

endmodule

// File: rtl/trng_bram_arbiter.sv
// trng_bram_arbiter: shares one BRAM port between the TRNG word writer and
// a host reader, running the BRAM as a circular FIFO.
//   clk, rst (async, active-low), flush (sync FIFO clear)
//   wr_req/wr_data/wr_gnt : writer side, grant is combinational
//   rd_req/rd_gnt         : reader side, grant is combinational
//   rd_data/rd_valid      : read word, valid RD_LAT+1 cycles after rd_gnt
//   level/full/empty      : FIFO occupancy from the registered level
//   bram_*                : BRAM primitive port (registered en/we/addr/din)
// Optional: define TRNG_ARB_OVERFLOW_CNT_EN to add ovf_cnt[15:0], a
// saturating count of cycles with wr_req while full.
module trng_bram_arbiter
  import trng_bram_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int BRAM_DEPTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_req,
  input  logic [DW-1:0]                 wr_data,
  output logic                          wr_gnt,
  input  logic                          rd_req,
  output logic                          rd_gnt,
  output logic [DW-1:0]                 rd_data,
  output logic                          rd_valid,
  output logic [$clog2(BRAM_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty,
  output logic                          bram_rst,
  output logic                          bram_clk,
  output logic                          bram_en,
  output logic [3:0]                    bram_we,
  output logic [AW-1:0]                 bram_addr,
  output logic [DW-1:0]                 bram_din,
  input  logic [DW-1:0]                 bram_dout
`ifdef TRNG_ARB_OVERFLOW_CNT_EN
  ,
  output logic [15:0]                   ovf_cnt
`endif
);

  localparam int PW = $clog2(BRAM_DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] lvl;
  arb_sel_e      rr_last;
  logic          wr_elig, rd_elig;

  assign level = lvl;
  assign full  = (lvl == LW'(BRAM_DEPTH));
  assign empty = (lvl == '0);

  assign wr_elig = wr_req && !full;
  assign rd_elig = rd_req && !empty;

  // Under contention the side that did not win last time gets the port.
  // Grants are held off while reset is asserted so nothing is offered
  // to either client before the FIFO state is valid.
  assign wr_gnt = rst && !flush && wr_elig && (!rd_elig || rr_last == ARB_RD);
  assign rd_gnt = rst && !flush && rd_elig && (!wr_elig || rr_last == ARB_WR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lvl       <= '0;
      rr_last   <= ARB_WR;
      bram_en   <= 1'b0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      bram_en <= wr_gnt || rd_gnt;
      bram_we <= wr_gnt ? BYTE_WE_ALL : 4'h0;
      if (wr_gnt) begin
        bram_addr <= AW'(wr_ptr) << ADDR_SHIFT;
        bram_din  <= wr_data;
      end else if (rd_gnt) begin
        bram_addr <= AW'(rd_ptr) << ADDR_SHIFT;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lvl    <= '0;
      end else if (wr_gnt) begin
        wr_ptr  <= wr_ptr + PW'(1);
        lvl     <= lvl + LW'(1);
        rr_last <= ARB_WR;
      end else if (rd_gnt) begin
        rd_ptr  <= rd_ptr + PW'(1);
        lvl     <= lvl - LW'(1);
        rr_last <= ARB_RD;
      end
    end
  end

  trng_bram_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .issue (rd_gnt),
    .valid (rd_valid)
  );

  assign rd_data  = bram_dout;
  assign bram_rst = ~rst;
  assign bram_clk = clk;

`ifdef TRNG_ARB_OVERFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  ovf_cnt <= '0;
    else if (flush)                            ovf_cnt <= '0;
    else if (wr_req && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

endmodule
